// File: rtl/enc_quad_decoder.sv
// Quadrature decoder for the debounced PmodENC A/B channels: step pulses,
// direction, bounded position counter and illegal-transition detection.
module enc_quad_decoder #(
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned COUNT_MAX = 255,
  parameter int unsigned DETENT    = 1,
  parameter int unsigned WRAP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_in,
  input  logic               b_in,
  input  logic               clr,
  output logic               step_cw,
  output logic               step_ccw,
  output logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               err,
  output logic               err_flag
);

  localparam logic [COUNT_W-1:0] CMAX   = COUNT_W'(COUNT_MAX);
  localparam logic signed [2:0]  PH_MAX = 3'sb011;
  localparam logic signed [2:0]  PH_MIN = 3'sb101;

  logic [1:0]         prev_ab;
  logic [1:0]         cur;
  logic signed [2:0]  ph;
  logic signed [2:0]  ph_n;
  logic               primed;
  logic               cw_q;
  logic               ccw_q;
  logic               bad;
  logic               up;
  logic               down;
  logic [COUNT_W-1:0] count_n;

  // Classify the transition from the last accepted AB to the current one.
  always_comb begin
    cur   = {a_in, b_in};
    cw_q  = 1'b0;
    ccw_q = 1'b0;
    case ({prev_ab, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: cw_q  = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: ccw_q = 1'b1;
      default: ;
    endcase
    bad = primed && ((prev_ab ^ cur) == 2'b11);
  end

  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    ph_n    = ph;
    count_n = count;
    if (primed) begin
      if (bad) begin
        if (cur == 2'b00) ph_n = 3'sb000;
      end else if (cw_q) begin
        if (DETENT == 0) begin
          up = 1'b1;
        end else if (cur == 2'b00) begin
          up   = (ph == PH_MAX);
          ph_n = 3'sb000;
        end else begin
          ph_n = (ph == PH_MAX) ? PH_MAX : ph + 3'sb001;
        end
      end else if (ccw_q) begin
        if (DETENT == 0) begin
          down = 1'b1;
        end else if (cur == 2'b00) begin
          down = (ph == PH_MIN);
          ph_n = 3'sb000;
        end else begin
          ph_n = (ph == PH_MIN) ? PH_MIN : ph - 3'sb001;
        end
      end
    end
    // Bounded count: wrap or saturate at the ends.
    if (up) begin
      if (count >= CMAX) count_n = (WRAP != 0) ? '0 : CMAX;
      else               count_n = count + COUNT_W'(1);
    end else if (down) begin
      if (count == '0)   count_n = (WRAP != 0) ? CMAX : '0;
      else               count_n = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      dir      <= 1'b0;
      count    <= '0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      ph       <= 3'sb000;
      prev_ab  <= 2'b00;
      primed   <= 1'b0;
    end else begin
      step_cw  <= up;
      step_ccw <= down;
      err      <= bad;
      if (up)        dir <= 1'b1;
      else if (down) dir <= 1'b0;
      prev_ab  <= cur;
      primed   <= 1'b1;
      if (clr) begin
        count    <= '0;
        ph       <= 3'sb000;
        err_flag <= 1'b0;
      end else begin
        count    <= count_n;
        ph       <= ph_n;
        err_flag <= err_flag | bad;
      end
    end
  end

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Scoreboard bench for enc_quad_decoder: default build plus an x4 saturating build.
module tb_enc_quad_decoder;

  typedef struct {
    logic [2:0] k;   // {err, step_ccw, step_cw}
    logic [7:0] c;
    logic       d;
    logic       f;
    int         cy;
  } exp_t;

  localparam logic [2:0] CW  = 3'b001;
  localparam logic [2:0] CCW = 3'b010;
  localparam logic [2:0] ERR = 3'b100;
  localparam logic [2:0] NON = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a0 = 1'b0, b0 = 1'b0, clr0 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
  logic cw0, ccw0, dir0, err0, ef0;
  logic cw1, ccw1, dir1, err1, ef1;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enc_quad_decoder u0 (
    .clk(clk), .rst(rst), .a_in(a0), .b_in(b0), .clr(clr0),
    .step_cw(cw0), .step_ccw(ccw0), .dir(dir0), .count(cnt0),
    .err(err0), .err_flag(ef0)
  );

  enc_quad_decoder #(.COUNT_W(8), .COUNT_MAX(3), .DETENT(0), .WRAP(0)) u1 (
    .clk(clk), .rst(rst), .a_in(a1), .b_in(b1), .clr(clr1),
    .step_cw(cw1), .step_ccw(ccw1), .dir(dir1), .count(cnt1),
    .err(err1), .err_flag(ef1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input exp_t e, input logic [2:0] k,
                        input logic [7:0] c, input logic d, input logic f);
    checks++;
    if (k !== e.k || c !== e.c || d !== e.d || f !== e.f || cyc != e.cy) begin
      errors++;
      $display("FAIL %s: got k=%b cnt=%0d dir=%b ef=%b cyc=%0d expected k=%b cnt=%0d dir=%b ef=%b cyc=%0d",
               name, k, c, d, f, cyc, e.k, e.c, e.d, e.f, e.cy);
    end
  endtask

  // Monitors: every pulse cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (cw0 || ccw0 || err0)) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected: got k=%b cnt=%0d at cyc=%0d expected no pulse",
                 {err0, ccw0, cw0}, cnt0, cyc);
      end else begin
        cmp_ev("u0_event", q0.pop_front(), {err0, ccw0, cw0}, cnt0, dir0, ef0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (cw1 || ccw1 || err1)) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected: got k=%b cnt=%0d at cyc=%0d expected no pulse",
                 {err1, ccw1, cw1}, cnt1, cyc);
      end else begin
        cmp_ev("u1_event", q1.pop_front(), {err1, ccw1, cw1}, cnt1, dir1, ef1);
      end
    end
  end

  // Called at a negedge: apply AB, queue the expected pulse, hold 8 cycles.
  task automatic drv0(input logic [1:0] ab, input logic [2:0] k, input logic [7:0] c,
                      input logic d, input logic f);
    exp_t e;
    a0 = ab[1]; b0 = ab[0];
    if (k != NON) begin
      e = '{k: k, c: c, d: d, f: f, cy: cyc + 1};
      q0.push_back(e);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic drv1(input logic [1:0] ab, input logic [2:0] k, input logic [7:0] c,
                      input logic d);
    exp_t e;
    a1 = ab[1]; b1 = ab[0];
    e = '{k: k, c: c, d: d, f: 1'b0, cy: cyc + 1};
    q1.push_back(e);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_dir", 32'(dir0), 32'd0);
    chk("rst_err_flag", 32'(ef0), 32'd0);
    chk("rst_steps", 32'({err0, ccw0, cw0}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // One full CW detent.
    drv0(2'b10, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b11, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, CW,  8'd1, 1'b1, 1'b0);
    chk("cw_count", 32'(cnt0), 32'd1);
    chk("cw_dir", 32'(dir0), 32'd1);

    // Three CCW detents from zero wrap downward.
    pulse_clr0();
    chk("clr_count", 32'(cnt0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
      drv0(2'b11, NON, 8'd0, 1'b0, 1'b0);
      drv0(2'b10, NON, 8'd0, 1'b0, 1'b0);
      drv0(2'b00, CCW, 8'(255 - i), 1'b0, 1'b0);
    end
    chk("ccw_dir", 32'(dir0), 32'd0);

    // Bounce then a full CW detent.
    pulse_clr0();
    drv0(2'b10, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b10, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b11, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, CW,  8'd1, 1'b1, 1'b0);
    chk("bounce_count", 32'(cnt0), 32'd1);

    // Illegal jump, then a partial return that must not count.
    drv0(2'b11, ERR, 8'd1, 1'b1, 1'b1);
    drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, NON, 8'd0, 1'b0, 1'b0);
    chk("illegal_flag", 32'(ef0), 32'd1);
    chk("illegal_count", 32'(cnt0), 32'd1);
    pulse_clr0();
    chk("clr_err_flag", 32'(ef0), 32'd0);
    chk("clr_count2", 32'(cnt0), 32'd0);

    // Reset while resting at 11, re-prime, then rotate.
    rst = 1'b1; a0 = 1'b1; b0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("prime_err_flag", 32'(ef0), 32'd0);
    drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, NON, 8'd0, 1'b0, 1'b0);
    chk("prime_nocount", 32'(cnt0), 32'd0);
    drv0(2'b10, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b11, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b01, NON, 8'd0, 1'b0, 1'b0);
    drv0(2'b00, CW,  8'd1, 1'b1, 1'b0);
    chk("prime_count", 32'(cnt0), 32'd1);

    // x4 mode, saturating at 3 and at 0.
    drv1(2'b10, CW, 8'd1, 1'b1);
    drv1(2'b11, CW, 8'd2, 1'b1);
    drv1(2'b01, CW, 8'd3, 1'b1);
    drv1(2'b00, CW, 8'd3, 1'b1);
    drv1(2'b10, CW, 8'd3, 1'b1);
    drv1(2'b11, CW, 8'd3, 1'b1);
    drv1(2'b10, CCW, 8'd2, 1'b0);
    drv1(2'b00, CCW, 8'd1, 1'b0);
    drv1(2'b01, CCW, 8'd0, 1'b0);
    drv1(2'b11, CCW, 8'd0, 1'b0);
    chk("x4_count", 32'(cnt1), 32'd0);
    chk("x4_err_flag", 32'(ef1), 32'd0);

    repeat (4) @(negedge clk);
    chk("u0_queue_empty", 32'(q0.size()), 32'd0);
    chk("u1_queue_empty", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
